// File: rtl/sample_frame_tx.sv
// Buffers sample words in a FIFO and sends each one as a framed byte packet over a UART handshake.
// Define FRAME_CHECKSUM_EN to append a two's-complement checksum byte to every frame.
module sample_frame_tx #(
   parameter int unsigned SAMPLE_W   = 22,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [7:0]  SYNC_BYTE  = 8'hAA
) (
   input  logic                          clk100,
   input  logic                          rst,
   input  logic                          sample_valid,
   input  logic [SAMPLE_W-1:0]           sample_data,
   input  logic                          tx_ready,
   output logic [7:0]                    tx_byte,
   output logic                          tx_en,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] DepthL = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StSync, StSeq, StD2, StD1, StD0, StCsum} state_e;

   state_e              state_q, state_d;
   logic                guard_q, guard_d;
   logic [23:0]         frame_q;
   logic [7:0]          seq_q, cnt_q;
   logic [7:0]          tx_byte_q, tx_byte_d;
   logic                tx_en_q, tx_en_d;
   logic                overflow_q;
   logic [LW-1:0]       level_q;
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
   logic                push, pop, full;
   logic [7:0]          cur_byte;
   state_e              next_byte_state;

   assign full = (level_q == DepthL);
   assign push = sample_valid && !full;

`ifdef FRAME_CHECKSUM_EN
   logic [7:0] csum_sum, csum;
   assign csum_sum = seq_q + frame_q[23:16] + frame_q[15:8] + frame_q[7:0];
   assign csum     = 8'h00 - csum_sum;
`endif

   always_comb begin
      cur_byte        = SYNC_BYTE;
      next_byte_state = StIdle;
      unique case (state_q)
         StSync: begin cur_byte = SYNC_BYTE;      next_byte_state = StSeq; end
         StSeq:  begin cur_byte = seq_q;          next_byte_state = StD2;  end
         StD2:   begin cur_byte = frame_q[23:16]; next_byte_state = StD1;  end
         StD1:   begin cur_byte = frame_q[15:8];  next_byte_state = StD0;  end
`ifdef FRAME_CHECKSUM_EN
         StD0:   begin cur_byte = frame_q[7:0];   next_byte_state = StCsum; end
         StCsum: begin cur_byte = csum;           next_byte_state = StIdle; end
`else
         StD0:   begin cur_byte = frame_q[7:0];   next_byte_state = StIdle; end
`endif
         default: ;
      endcase
   end

   // Each byte state is a SEND phase (guard_q=0) followed by one GUARD cycle (guard_q=1).
   always_comb begin
      state_d   = state_q;
      guard_d   = guard_q;
      tx_byte_d = tx_byte_q;
      tx_en_d   = 1'b0;
      pop       = 1'b0;
      if (state_q == StIdle) begin
         if (level_q != '0 && tx_ready) begin
            pop     = 1'b1;
            state_d = StSync;
            guard_d = 1'b0;
         end
      end else if (guard_q) begin
         guard_d = 1'b0;
         state_d = next_byte_state;
      end else if (tx_ready) begin
         tx_en_d   = 1'b1;
         tx_byte_d = cur_byte;
         guard_d   = 1'b1;
      end
   end

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         guard_q    <= 1'b0;
         frame_q    <= '0;
         seq_q      <= '0;
         cnt_q      <= '0;
         tx_byte_q  <= '0;
         tx_en_q    <= 1'b0;
         overflow_q <= 1'b0;
         level_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q   <= state_d;
         guard_q   <= guard_d;
         tx_byte_q <= tx_byte_d;
         tx_en_q   <= tx_en_d;
         if (sample_valid && full) overflow_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            frame_q  <= 24'(mem_q[rd_ptr_q]);
            seq_q    <= cnt_q;
            cnt_q    <= cnt_q + 8'd1;
         end
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   // Storage needs no reset: only entries below level_q are ever read.
   always_ff @(posedge clk100) begin
      if (push) mem_q[wr_ptr_q] <= sample_data;
   end

   assign tx_byte    = tx_byte_q;
   assign tx_en      = tx_en_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != StIdle) || (level_q != '0);

endmodule
